mem_access_stage: RTL

- MEM stage of the 5-stage pipeline; sits directly downstream of the EX-stage ALU.
- Consumes the ALU result (the effective address for loads and stores, otherwise the writeback value), the forwarded rs2 store data and the 6-bit ALU control code.
- Drives a single-outstanding req/ack data-memory port, handling byte-lane steering, load extension and misalignment detection.
- Registers the MEM/WB outputs, which also feed the ALU's mem_wb forwarding input.

---
 rtl/mem_access_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: single-outstanding req/ack data-memory access with byte-lane steering,
// load extension, misalignment detection and an ack timeout. MEM/WB outputs are registered.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 16,
  parameter int TCNT_W      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [5:0]  alu_control,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_wb_valid,
  output logic [31:0] mem_wb_result,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_reg_write,
  output logic        misalign_exc,
  output logic        bus_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [5:0] OP_LB  = 6'b010100;
  localparam logic [5:0] OP_LH  = 6'b010101;
  localparam logic [5:0] OP_LW  = 6'b010110;
  localparam logic [5:0] OP_LBU = 6'b010111;
  localparam logic [5:0] OP_LHU = 6'b011000;
  localparam logic [5:0] OP_SB  = 6'b011001;
  localparam logic [5:0] OP_SH  = 6'b011010;
  localparam logic [5:0] OP_SW  = 6'b011011;

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(ACK_TIMEOUT - 1);

  logic [0:0]        state;
  logic [TCNT_W-1:0] tcnt;
  logic [5:0]        op_q;
  logic [1:0]        ofs_q;
  logic [4:0]        rd_q;
  logic              reg_write_q;

  logic        take, is_store, is_mem, misaligned;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n, load_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign in_ready = (state == IDLE);
  assign take     = in_valid && in_ready;

  always_comb begin
    is_store   = (alu_control >= OP_SB) && (alu_control <= OP_SW);
    is_mem     = ((alu_control >= OP_LB) && (alu_control <= OP_LHU)) || is_store;
    misaligned = 1'b0;
    wstrb_n    = 4'b0000;
    wdata_n    = store_data;
    case (alu_control)
      OP_LH, OP_LHU: misaligned = alu_result[0];
      OP_LW:         misaligned = |alu_result[1:0];
      OP_SB: begin
        wstrb_n = 4'b0001 << alu_result[1:0];
        wdata_n = {4{store_data[7:0]}};
      end
      OP_SH: begin
        misaligned = alu_result[0];
        wstrb_n    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_n    = {2{store_data[15:0]}};
      end
      OP_SW: begin
        misaligned = |alu_result[1:0];
        wstrb_n    = 4'b1111;
      end
      default: ;
    endcase
  end

  // Lane selection uses the byte offset captured with the request.
  always_comb begin
    case (ofs_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = ofs_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_q)
      OP_LB:   load_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_val = {24'd0, ld_byte};
      OP_LH:   load_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_val = {16'd0, ld_half};
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      tcnt             <= '0;
      op_q             <= '0;
      ofs_q            <= '0;
      rd_q             <= '0;
      reg_write_q      <= 1'b0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_wstrb       <= '0;
      dmem_wdata       <= '0;
      mem_wb_valid     <= 1'b0;
      mem_wb_result    <= '0;
      mem_wb_rd        <= '0;
      mem_wb_reg_write <= 1'b0;
      misalign_exc     <= 1'b0;
      bus_err          <= 1'b0;
    end else begin
      mem_wb_valid <= 1'b0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            if (!is_mem) begin
              mem_wb_valid     <= 1'b1;
              mem_wb_result    <= alu_result;
              mem_wb_rd        <= rd;
              mem_wb_reg_write <= reg_write && (rd != 5'd0);
            end else if (misaligned) begin
              misalign_exc <= 1'b1;
            end else begin
              state       <= BUSY;
              tcnt        <= '0;
              dmem_req    <= 1'b1;
              dmem_we     <= is_store;
              dmem_addr   <= {alu_result[31:2], 2'b00};
              dmem_wstrb  <= wstrb_n;
              dmem_wdata  <= wdata_n;
              op_q        <= alu_control;
              ofs_q       <= alu_result[1:0];
              rd_q        <= rd;
              reg_write_q <= reg_write;
            end
          end
        end
        BUSY: begin
          // Ack beats the timeout when both land in the same cycle.
          if (dmem_ack) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            mem_wb_valid <= 1'b1;
            mem_wb_rd    <= rd_q;
            if (dmem_we) begin
              mem_wb_reg_write <= 1'b0;
            end else begin
              mem_wb_result    <= load_val;
              mem_wb_reg_write <= reg_write_q && (rd_q != 5'd0);
            end
          end else if (tcnt == TCNT_LAST) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
